ladybird_ifetch: RTL

Instruction prefetch stage upstream of `ladybird_core`. Issues sequential word fetches on the instruction bus and buffers fetched instructions with their PCs in a small FIFO. Hands them to the core over a valid/ready handshake. A redirect from the core (taken jump) flushes the buffer and discards any in-flight response.

---
 rtl/ladybird_config.sv | 12 +
 rtl/ladybird_fifo.sv | 55 +++++
 rtl/ladybird_ifetch.sv | 103 ++++++++++
 3 files changed

// File: rtl/ladybird_config.sv
// Shared configuration for the ladybird core and its front end.
package ladybird_config;

  localparam int XLEN         = 32;
  localparam int IFETCH_DEPTH = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } fetch_entry_t;

endpackage

// File: rtl/ladybird_fifo.sv
// Generic synchronous FIFO with clear; DEPTH must be a power of two, at least 2.
module ladybird_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [31:0],
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          anrst,
  input  logic          i_push,
  input  T              i_data,
  input  logic          i_pop,
  input  logic          i_clear,
  output T              o_head,
  output logic [CW-1:0] o_count
);

  T                r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_do_pop;
  logic            w_do_push;

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/ladybird_ifetch.sv
// Instruction prefetch: sequential word fetches buffered with their PCs,
// handed to the core over valid/ready; redirects flush and drop in-flight data.
//
// state | meaning
// BOOT  | first cycle out of reset, no request
// IDLE  | nothing outstanding
// WAIT  | one request outstanding, response kept
// DRAIN | one request outstanding, response discarded
module ladybird_ifetch
  import ladybird_config::*;
#(
  parameter int              DEPTH    = IFETCH_DEPTH,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
  input  logic            clk,
  input  logic            anrst,
  output logic            bus_req,
  output logic [XLEN-1:0] bus_addr,
  input  logic            bus_gnt,
  input  logic [31:0]     bus_data,
  output logic            out_valid,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  input  logic            out_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    IDLE  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } ifetch_state_t;

  ifetch_state_t   r_state;
  ifetch_state_t   w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_req_pc;
  logic [CW-1:0]   w_count;
  logic            w_push;
  logic            w_pop;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;

  assign bus_req   = (r_state == IDLE) && (w_count != CW'(DEPTH)) && !redirect_valid;
  assign bus_addr  = r_fetch_pc;
  assign out_valid = (w_count != '0);
  assign out_inst  = w_head.inst;
  assign out_pc    = w_head.pc;

  // A redirect in the grant cycle wins: the data is dropped and the FIFO cleared.
  assign w_push       = (r_state == WAIT) && bus_gnt && !redirect_valid;
  assign w_pop        = out_valid && out_ready;
  assign w_push_entry = '{pc: r_req_pc, inst: bus_data};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOOT:  w_state_nxt = IDLE;
      IDLE:  if (bus_req) w_state_nxt = WAIT;
      WAIT: begin
        if (bus_gnt)             w_state_nxt = IDLE;
        else if (redirect_valid) w_state_nxt = DRAIN;
      end
      DRAIN: if (bus_gnt) w_state_nxt = IDLE;
      default: w_state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      r_state    <= BOOT;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc;
      end else if (bus_req) begin
        r_req_pc   <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
    end
  end

  ladybird_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clk     (clk),
    .anrst   (anrst),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .i_clear (redirect_valid),
    .o_head  (w_head),
    .o_count (w_count)
  );

endmodule
